// File: rtl/haze_pkg.sv
// Shared definitions for the haze-removal pixel pipeline: pixel format,
// default line width and the row-fill tracking type used by the tap stages.
package haze_pkg;

  localparam int PIX_W             = 8;
  localparam int DEFAULT_IMG_WIDTH = 640;

  typedef logic [PIX_W-1:0] pixel_t;

  // How many complete rows are held in the line buffers (saturates at two).
  typedef enum logic [1:0] {
    FILL_0 = 2'd0,
    FILL_1 = 2'd1,
    FILL_2 = 2'd2
  } row_fill_e;

endpackage

// File: rtl/line_ram.sv
// Single-port line buffer with combinational read-first access; the parent
// registers the read data so this maps to distributed or read-first block RAM.
module line_ram #(
  parameter int DEPTH  = 640,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/column_tap3.sv
// Three-row column tap generator: buffers the two previous rows and presents
// the vertically aligned (r-2, r-1, r) triple for every accepted pixel.
module column_tap3 #(
  parameter int IMG_WIDTH = haze_pkg::DEFAULT_IMG_WIDTH,
  parameter int PIX_W     = haze_pkg::PIX_W,
  parameter int COL_W     = $clog2(IMG_WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Enable,
  input  logic             frame_start,
  input  logic [PIX_W-1:0] pixel_in,
  output logic [PIX_W-1:0] tap_a,
  output logic [PIX_W-1:0] tap_b,
  output logic [PIX_W-1:0] tap_c,
  output logic             tap_valid,
  output logic [COL_W-1:0] tap_col
);

  import haze_pkg::*;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  logic [COL_W-1:0] col;
  logic [COL_W-1:0] cur_col;
  logic [COL_W-1:0] next_col;
  row_fill_e        row_fill;
  row_fill_e        cur_fill;
  row_fill_e        next_fill;
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;
  logic             accept;

  assign accept = Enable && !reset;

  // frame_start retargets the current pixel to col 0 of an empty frame,
  // which also discards any partially captured row.
  always_comb begin
    cur_col   = frame_start ? '0 : col;
    cur_fill  = frame_start ? FILL_0 : row_fill;
    next_col  = cur_col + COL_W'(1);
    next_fill = cur_fill;
    if (cur_col == LAST_COL) begin
      next_col = '0;
      if (cur_fill != FILL_2) begin
        next_fill = row_fill_e'(cur_fill + 2'd1);
      end
    end
  end

  line_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W),
    .ADDR_W(COL_W)
  ) lb0 (
    .clock(clock),
    .we   (accept),
    .addr (cur_col),
    .wdata(pixel_in),
    .rdata(lb0_rd)
  );

  line_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W),
    .ADDR_W(COL_W)
  ) lb1 (
    .clock(clock),
    .we   (accept),
    .addr (cur_col),
    .wdata(lb0_rd),
    .rdata(lb1_rd)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      col       <= '0;
      row_fill  <= FILL_0;
      tap_a     <= '0;
      tap_b     <= '0;
      tap_c     <= '0;
      tap_col   <= '0;
      tap_valid <= 1'b0;
    end else if (Enable) begin
      col       <= next_col;
      row_fill  <= next_fill;
      tap_a     <= lb1_rd;
      tap_b     <= lb0_rd;
      tap_c     <= pixel_in;
      tap_col   <= cur_col;
      tap_valid <= (cur_fill == FILL_2);
    end else begin
      tap_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_column_tap3.sv
// Directed bench for column_tap3 at IMG_WIDTH=4: table-driven fill/wrap/gap
// vectors plus hand-written restart, reset and priority sequences.
module tb_column_tap3;

  localparam int W  = 4;
  localparam int PW = 8;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          Enable;
  logic          frame_start;
  logic [PW-1:0] pixel_in;
  logic [PW-1:0] tap_a;
  logic [PW-1:0] tap_b;
  logic [PW-1:0] tap_c;
  logic          tap_valid;
  logic [CW-1:0] tap_col;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic          en;
    logic          fs;
    logic [PW-1:0] pix;
    logic [PW-1:0] a;
    logic [PW-1:0] b;
    logic [PW-1:0] c;
    logic [CW-1:0] col;
    logic          valid;
    logic          chk_a;
    logic          chk_b;
  } vec_t;

  vec_t vecs[$];

  column_tap3 #(.IMG_WIDTH(W), .PIX_W(PW), .COL_W(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .Enable     (Enable),
    .frame_start(frame_start),
    .pixel_in   (pixel_in),
    .tap_a      (tap_a),
    .tap_b      (tap_b),
    .tap_c      (tap_c),
    .tap_valid  (tap_valid),
    .tap_col    (tap_col)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic fs, input logic [PW-1:0] pix);
    reset       = rst;
    Enable      = en;
    frame_start = fs;
    pixel_in    = pix;
    @(posedge clock);
    #1;
  endtask

  task automatic checkTaps(input string tag, input logic [PW-1:0] a, input logic [PW-1:0] b,
                           input logic [PW-1:0] c, input logic [CW-1:0] col, input logic valid,
                           input logic chk_a, input logic chk_b);
    if (chk_a) checkOutput({tag, ".tap_a"}, 32'(tap_a), 32'(a));
    if (chk_b) checkOutput({tag, ".tap_b"}, 32'(tap_b), 32'(b));
    checkOutput({tag, ".tap_c"}, 32'(tap_c), 32'(c));
    checkOutput({tag, ".tap_col"}, 32'(tap_col), 32'(col));
    checkOutput({tag, ".tap_valid"}, 32'(tap_valid), 32'(valid));
  endtask

  task automatic checkZero(input string tag);
    checkTaps(tag, '0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  // Stream n contiguous pixels base, base+1, ... as a fresh frame.
  task automatic streamFrame(input string tag, input logic [PW-1:0] base, input int n, input logic first_fs);
    for (int q = 0; q < n; q++) begin
      logic [PW-1:0] p;
      p = base + PW'(q);
      applyStimulus(1'b0, 1'b1, first_fs && (q == 0), p);
      checkTaps($sformatf("%s[%0d]", tag, q), p - PW'(2*W), p - PW'(W), p,
                CW'(q % W), q >= 2*W, q >= 2*W, q >= W);
    end
  endtask

  initial begin
    vec_t v;
    vec_t prev;

    // Contiguous fill through the row wrap into row 3.
    for (int p = 0; p < 16; p++) begin
      v.en    = 1'b1;
      v.fs    = (p == 0);
      v.pix   = PW'(p);
      v.c     = PW'(p);
      v.b     = PW'(p - W);
      v.a     = PW'(p - 2*W);
      v.col   = CW'(p % W);
      v.valid = (p >= 2*W);
      v.chk_b = (p >= W);
      v.chk_a = (p >= 2*W);
      vecs.push_back(v);
    end
    // Same stream with idle cycles between pixels; idle frame_start is ignored.
    for (int p = 0; p < 12; p++) begin
      v.en    = 1'b1;
      v.fs    = (p == 0);
      v.pix   = PW'(p);
      v.c     = PW'(p);
      v.b     = PW'(p - W);
      v.a     = PW'(p - 2*W);
      v.col   = CW'(p % W);
      v.valid = (p >= 2*W);
      v.chk_b = (p >= W);
      v.chk_a = (p >= 2*W);
      vecs.push_back(v);
      prev       = v;
      prev.en    = 1'b0;
      prev.fs    = 1'b1;
      prev.pix   = 8'hFF;
      prev.valid = 1'b0;
      vecs.push_back(prev);
    end

    reset       = 1'b1;
    Enable      = 1'b0;
    frame_start = 1'b0;
    pixel_in    = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkZero("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1'b0, vecs[i].en, vecs[i].fs, vecs[i].pix);
      checkTaps($sformatf("vec[%0d]", i), vecs[i].a, vecs[i].b, vecs[i].c,
                vecs[i].col, vecs[i].valid, vecs[i].chk_a, vecs[i].chk_b);
    end

    streamFrame("pre_restart", 8'h00, 10, 1'b1);
    streamFrame("restart", 8'hAA, 12, 1'b1);

    streamFrame("pre_reset", 8'h30, 10, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h77);
    checkZero("mid_reset");
    streamFrame("post_reset", 8'h50, 12, 1'b0);

    streamFrame("pre_prio", 8'h10, 10, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hEE);
    checkZero("prio_reset");
    streamFrame("post_prio", 8'h60, 12, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
